prev_parity_ring: RTL and testbench
===================================

Name: prev_parity_ring

Overview:
- Parametrised successor to the fixed 5-bit previous-parity register used in the ColParity/theta datapath.
- Holds the lane-rotated column parity of the previous slice for a full pass of DEPTH slices.
- Captures slice 0's rotated parity for the wrap-around term, and sequences the pass with a small FSM.
- Sits between the column-parity generator and the theta XOR stage.

Parameters:
- W, 5, number of lanes (columns) per slice parity word.
- ROT, 2, lane rotation: out[i] = in[(i + W - ROT) mod W]; 0 <= ROT < W.
- DEPTH, 64, slices per pass; DEPTH >= 2.
- CW, $clog2(DEPTH), slice counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  begins a pass; honoured only in IDLE.
- par_in  input  W  column parity of the current slice.
- par_valid  input  1  par_in valid this cycle; honoured only in RUN.
- prev_par  output  W  rotated parity of the most recently accepted slice.
- prev_valid  output  1  at least one slice accepted in the current pass.
- first_par  output  W  rotated parity of slice 0 of the current/last pass.
- slice_idx  output  CW  index of the next slice expected.
- busy  output  1  FSM in RUN or WRAP.
- wrap_valid  output  1  one-cycle pulse in WRAP; prev_par = slice DEPTH-1, first_par = slice 0.
- done  output  1  one-cycle pulse on the cycle after WRAP (back in IDLE).

Behaviour:
- Reset: rst sampled at posedge clk only. FSM->IDLE; prev_par, first_par, slice_idx = 0; prev_valid, wrap_valid, done, busy = 0.
- rst has priority over every other input. Reset mid-pass aborts the pass: no wrap_valid, no done.
- Rotation is purely combinational on par_in. The registered value is rot(par_in). Example, W=5, ROT=2: out = {in[2], in[1], in[0], in[4], in[3]} (MSB first).
- States: IDLE, RUN, WRAP. All outputs are registered or decoded directly from state; no combinational path from inputs to outputs.
- IDLE:
  - busy = 0.
  - start -> RUN. Same edge: slice_idx <= 0, prev_valid <= 0.
  - prev_par and first_par keep their last values.
  - par_valid is ignored.
- RUN:
  - busy = 1. start is ignored.
  - On par_valid: prev_par <= rot(par_in) and prev_valid <= 1.
  - If slice_idx == 0, also first_par <= rot(par_in).
  - If slice_idx == DEPTH-1 -> WRAP and slice_idx <= 0; else slice_idx <= slice_idx + 1.
  - Without par_valid all registers hold (load-enable semantics). Gaps of any length are allowed.
- WRAP: exactly one cycle.
  - wrap_valid = 1, busy = 1. par_valid and start are ignored.
  - Next state is IDLE, with done = 1 in that first IDLE cycle.
- done and wrap_valid are never high together and never high for more than one cycle.
- start arriving in the IDLE cycle where done = 1 is honoured (back-to-back passes). Latency from the last par_valid to wrap_valid is 1 cycle; to done, 2 cycles.
- Counter wrap-around: slice_idx never exceeds DEPTH-1. Non-power-of-two DEPTH must work (explicit compare, not overflow).

Test Plan:
- Reset: hold rst 2 cycles with start=1 and par_valid=1 -> all outputs 0, state IDLE, busy=0.
- Rotation (W=5, ROT=2): start, then par_in=5'b00001 valid -> prev_par=5'b00100 and first_par=5'b00100 next cycle. Then par_in=5'b01000 -> prev_par=5'b00001, first_par still 5'b00100.
- Full pass (DEPTH=4): start, then par_in 1, 2, 4, 8 back-to-back -> slice_idx 1, 2, 3, 0. wrap_valid one cycle after the 4th beat with prev_par=5'b00001 and first_par=5'b00100; done the next cycle; busy falls with done.
- Gaps and ignores: in RUN insert 3 idle cycles between beats and pulse start -> prev_par and slice_idx hold, pass unaffected. par_valid in IDLE -> no change.
- Reset mid-pass: after 2 of 4 beats assert rst -> IDLE, outputs 0, no wrap_valid or done. A new pass then completes normally.
- Back-to-back: assert start in the done cycle -> second pass runs. Its first beat rewrites first_par; prev_valid is 0 until that beat.

Source files
------------

// File: rtl/prev_parity_ring_if.sv
// rtl/prev_parity_ring_if.sv - parity handshake and previous-parity result bundle
interface prev_parity_ring_if #(
  parameter int W  = 5,
  parameter int CW = 6
);
  logic          start;
  logic [W-1:0]  par_in;
  logic          par_valid;
  logic [W-1:0]  prev_par;
  logic          prev_valid;
  logic [W-1:0]  first_par;
  logic [CW-1:0] slice_idx;
  logic          busy;
  logic          wrap_valid;
  logic          done;

  modport master (
    output start, par_in, par_valid,
    input  prev_par, prev_valid, first_par, slice_idx, busy, wrap_valid, done
  );

  modport slave (
    input  start, par_in, par_valid,
    output prev_par, prev_valid, first_par, slice_idx, busy, wrap_valid, done
  );
endinterface

// File: rtl/prev_parity_ring.sv
// rtl/prev_parity_ring.sv - previous-slice rotated column parity register with pass sequencer
module prev_parity_ring #(
  parameter int W     = 5,
  parameter int ROT   = 2,
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  prev_parity_ring_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, WRAP} state_t;

  // Explicit compare so non-power-of-two pass lengths wrap correctly.
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  prev_par_q, prev_par_d;
  logic [W-1:0]  first_par_q, first_par_d;
  logic [CW-1:0] slice_idx_q, slice_idx_d;
  logic          prev_valid_q, prev_valid_d;
  logic          done_q, done_d;
  logic [W-1:0]  rot_par;

  // Lane rotation is pure wiring: out[i] = in[(i + W - ROT) mod W].
  for (genvar g = 0; g < W; g++) begin : g_rot
    assign rot_par[g] = bus.par_in[(g + W - ROT) % W];
  end

  // Next-state and register-load decisions for the pass sequencer.
  always_comb begin
    state_d      = state_q;
    prev_par_d   = prev_par_q;
    first_par_d  = first_par_q;
    slice_idx_d  = slice_idx_q;
    prev_valid_d = prev_valid_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d      = RUN;
          slice_idx_d  = '0;
          prev_valid_d = 1'b0;
        end
      end
      RUN: begin
        if (bus.par_valid) begin
          prev_par_d   = rot_par;
          prev_valid_d = 1'b1;
          if (slice_idx_q == '0) begin
            first_par_d = rot_par;
          end
          if (slice_idx_q == LAST_IDX) begin
            state_d     = WRAP;
            slice_idx_d = '0;
          end else begin
            slice_idx_d = slice_idx_q + CW'(1);
          end
        end
      end
      WRAP: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_par_q   <= '0;
      first_par_q  <= '0;
      slice_idx_q  <= '0;
      prev_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_par_q   <= prev_par_d;
      first_par_q  <= first_par_d;
      slice_idx_q  <= slice_idx_d;
      prev_valid_q <= prev_valid_d;
      done_q       <= done_d;
    end
  end

  assign bus.prev_par   = prev_par_q;
  assign bus.first_par  = first_par_q;
  assign bus.slice_idx  = slice_idx_q;
  assign bus.prev_valid = prev_valid_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.wrap_valid = (state_q == WRAP);

endmodule

// File: tb/tb_prev_parity_ring.sv
// tb/tb_prev_parity_ring.sv - scoreboard bench for prev_parity_ring (W=5, ROT=2, DEPTH=4)
module tb_prev_parity_ring;

  typedef struct {
    logic [4:0] prev_par;
    logic [4:0] first_par;
    logic [1:0] slice_idx;
    logic       prev_valid;
    logic       busy;
    logic       wrap_valid;
    logic       done;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  // Reference model state
  int         m_state;
  logic [4:0] m_prev;
  logic [4:0] m_first;
  logic [1:0] m_idx;
  logic       m_pv;
  logic       m_done;

  prev_parity_ring_if #(.W(5), .CW(2)) bus ();

  prev_parity_ring #(.W(5), .ROT(2), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] rot_exp(input logic [4:0] x);
    return {x[2], x[1], x[0], x[4], x[3]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic st, input logic pv, input logic [4:0] pin);
    logic was_wrap;
    was_wrap = (m_state == 2);
    if (r) begin
      m_state = 0; m_prev = '0; m_first = '0; m_idx = '0; m_pv = 1'b0; m_done = 1'b0;
    end else begin
      m_done = was_wrap;
      case (m_state)
        0: if (st) begin m_state = 1; m_idx = '0; m_pv = 1'b0; end
        1: if (pv) begin
          m_prev = rot_exp(pin);
          m_pv   = 1'b1;
          if (m_idx == 2'd0) m_first = rot_exp(pin);
          if (m_idx == 2'd3) begin m_state = 2; m_idx = '0; end
          else m_idx = m_idx + 2'd1;
        end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic cycle(input logic r, input logic st, input logic pv, input logic [4:0] pin);
    exp_t e;
    rst           = r;
    bus.start     = st;
    bus.par_valid = pv;
    bus.par_in    = pin;
    @(posedge clk);
    model_step(r, st, pv, pin);
    e.prev_par   = m_prev;
    e.first_par  = m_first;
    e.slice_idx  = m_idx;
    e.prev_valid = m_pv;
    e.busy       = (m_state != 0);
    e.wrap_valid = (m_state == 2);
    e.done       = m_done;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("prev_par",   32'(bus.prev_par),   32'(e.prev_par));
      check_eq("first_par",  32'(bus.first_par),  32'(e.first_par));
      check_eq("slice_idx",  32'(bus.slice_idx),  32'(e.slice_idx));
      check_eq("prev_valid", 32'(bus.prev_valid), 32'(e.prev_valid));
      check_eq("busy",       32'(bus.busy),       32'(e.busy));
      check_eq("wrap_valid", 32'(bus.wrap_valid), 32'(e.wrap_valid));
      check_eq("done",       32'(bus.done),       32'(e.done));
      check_eq("wrap_done_excl", 32'(bus.wrap_valid & bus.done), 32'd0);
    end
  endtask

  task automatic beat(input logic [4:0] pin);
    cycle(1'b0, 1'b0, 1'b1, pin);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_state = 0; m_prev = '0; m_first = '0; m_idx = '0; m_pv = 1'b0; m_done = 1'b0;
    rst = 1'b1; bus.start = 1'b0; bus.par_valid = 1'b0; bus.par_in = '0;

    // Reset with start and par_valid held high
    cycle(1'b1, 1'b1, 1'b1, 5'h1f);
    cycle(1'b1, 1'b1, 1'b1, 5'h1f);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_prev_par", 32'(bus.prev_par), 32'd0);
    check_eq("rst_first_par", 32'(bus.first_par), 32'd0);
    idle();

    // Rotation
    cycle(1'b0, 1'b1, 1'b0, 5'd0);
    check_eq("start_busy", 32'(bus.busy), 32'd1);
    beat(5'b00001);
    check_eq("rot_prev_1", 32'(bus.prev_par), 32'b00100);
    check_eq("rot_first_1", 32'(bus.first_par), 32'b00100);
    beat(5'b01000);
    check_eq("rot_prev_8", 32'(bus.prev_par), 32'b00001);
    check_eq("rot_first_hold", 32'(bus.first_par), 32'b00100);
    beat(5'b00010);
    check_eq("rot_prev_2", 32'(bus.prev_par), 32'b01000);
    beat(5'b00100);
    check_eq("rot_wrap", 32'(bus.wrap_valid), 32'd1);
    check_eq("rot_prev_4", 32'(bus.prev_par), 32'b10000);
    idle();
    check_eq("rot_done", 32'(bus.done), 32'd1);
    idle();

    // Full pass, back-to-back beats
    cycle(1'b0, 1'b1, 1'b0, 5'd0);
    beat(5'd1); check_eq("fp_idx1", 32'(bus.slice_idx), 32'd1);
    beat(5'd2); check_eq("fp_idx2", 32'(bus.slice_idx), 32'd2);
    beat(5'd4); check_eq("fp_idx3", 32'(bus.slice_idx), 32'd3);
    beat(5'd8); check_eq("fp_idx0", 32'(bus.slice_idx), 32'd0);
    check_eq("fp_wrap", 32'(bus.wrap_valid), 32'd1);
    check_eq("fp_wrap_prev", 32'(bus.prev_par), 32'b00001);
    check_eq("fp_wrap_first", 32'(bus.first_par), 32'b00100);
    idle();
    check_eq("fp_done", 32'(bus.done), 32'd1);
    check_eq("fp_busy_low", 32'(bus.busy), 32'd0);
    idle();
    check_eq("fp_done_once", 32'(bus.done), 32'd0);

    // par_valid in IDLE is ignored
    beat(5'h1f);
    check_eq("idle_pv_prev", 32'(bus.prev_par), 32'b00001);

    // Gaps and start pulses inside RUN
    cycle(1'b0, 1'b1, 1'b0, 5'd0);
    beat(5'h11);
    idle();
    cycle(1'b0, 1'b1, 1'b0, 5'd0);
    idle();
    check_eq("gap_idx_hold", 32'(bus.slice_idx), 32'd1);
    check_eq("gap_prev_hold", 32'(bus.prev_par), 32'(rot_exp(5'h11)));
    beat(5'h03); idle(); idle(); idle();
    beat(5'h18); idle();
    beat(5'h0c);
    check_eq("gap_wrap", 32'(bus.wrap_valid), 32'd1);
    idle(); idle();

    // Reset mid-pass
    cycle(1'b0, 1'b1, 1'b0, 5'd0);
    beat(5'h05);
    beat(5'h0a);
    cycle(1'b1, 1'b0, 1'b1, 5'h1f);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rst_idx", 32'(bus.slice_idx), 32'd0);
    check_eq("mid_rst_first", 32'(bus.first_par), 32'd0);
    idle(); idle();
    cycle(1'b0, 1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) beat(5'(i + 3));
    idle();
    check_eq("post_rst_done", 32'(bus.done), 32'd1);

    // Back-to-back: start in the done cycle
    cycle(1'b0, 1'b1, 1'b0, 5'd0);
    check_eq("b2b_busy", 32'(bus.busy), 32'd1);
    check_eq("b2b_pv_clear", 32'(bus.prev_valid), 32'd0);
    beat(5'b10000);
    check_eq("b2b_first", 32'(bus.first_par), 32'(rot_exp(5'b10000)));
    check_eq("b2b_pv_set", 32'(bus.prev_valid), 32'd1);
    for (int i = 0; i < 4; i++) idle();

    // Randomised traffic against the scoreboard model
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
